// File: rtl/caches_pkg.sv
// Shared types for the cache-side memory arbiter: arbitration mode, FSM state
// and the common machine word.
package caches_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating priority picker: lowest set request at or after
// i_ptr wins, searching upwards and wrapping modulo NUM_REQ.
module rr_priority_picker #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_found,
    output logic [IDX_W-1:0]   o_idx
);

    localparam logic [IDX_W:0] NUM_L = (IDX_W+1)'(NUM_REQ);

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [IDX_W-1:0]     w_off;
    logic [IDX_W:0]       w_sum;

    // Doubling the vector turns the wrap-around rotate into a plain shift.
    assign w_dbl   = {i_req, i_req} >> i_ptr;
    assign w_rot   = w_dbl[NUM_REQ-1:0];
    assign o_found = |i_req;

    // Priority-encode the rotated vector, lowest offset wins.
    always_comb begin
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_off = w_rot[k] ? IDX_W'(k) : w_off;
        end
    end

    // Un-rotate the winning offset back to a channel index.
    always_comb begin
        w_sum = {1'b0, w_off} + {1'b0, i_ptr};
        if (w_sum >= NUM_L) begin
            o_idx = IDX_W'(w_sum - NUM_L);
        end else begin
            o_idx = w_sum[IDX_W-1:0];
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// N-requestor arbiter between cache-side ports and one memory port; the grant
// is registered in IDLE and held through BUSY until completion or abort.
module cache_mem_arbiter
    import caches_pkg::*;
#(
    parameter  int        NUM_REQ  = 2,
    parameter  int        ADDR_W   = 32,
    parameter  int        DATA_W   = 64,
    parameter  arb_mode_t ARB_MODE = ARB_FIXED,
    localparam int        IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic [NUM_REQ-1:0]               req_ren,
    input  logic [NUM_REQ-1:0]               req_wen,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_store,
    output logic [NUM_REQ-1:0]               req_wait,
    output logic [NUM_REQ-1:0][DATA_W-1:0]   req_load,
    output logic                             mem_ren,
    output logic                             mem_wen,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [DATA_W-1:0]                mem_store,
    input  logic                             mem_wait,
    input  logic [DATA_W-1:0]                mem_load,
    output logic                             grant_valid,
    output logic [IDX_W-1:0]                 grant_idx
);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [IDX_W-1:0]   r_grant_idx;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   w_pick_ptr;
    logic [IDX_W-1:0]   w_pick_idx;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic               w_found;
    logic               w_done;
    logic [NUM_REQ-1:0] w_requesting;

    assign w_requesting = req_ren | req_wen;
    assign w_pick_ptr   = (ARB_MODE == ARB_RR) ? r_rr_ptr : '0;
    assign w_ptr_nxt    = (r_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                               : r_grant_idx + IDX_W'(1);
    assign grant_valid  = (r_state == ARB_BUSY);
    assign grant_idx    = r_grant_idx;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .i_req   (w_requesting),
        .i_ptr   (w_pick_ptr),
        .o_found (w_found),
        .o_idx   (w_pick_idx)
    );

    // State, grant and round-robin pointer registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= ARB_IDLE;
            r_grant_idx <= '0;
            r_rr_ptr    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ARB_IDLE) && w_found) begin
                r_grant_idx <= w_pick_idx;
            end
            if ((ARB_MODE == ARB_RR) && w_done) begin
                r_rr_ptr <= w_ptr_nxt;
            end
        end
    end

    // Next state plus memory pass-through; a dropped request aborts silently.
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        mem_ren     = 1'b0;
        mem_wen     = 1'b0;
        mem_addr    = '0;
        mem_store   = '0;
        req_wait    = w_requesting;
        req_load    = '0;
        case (r_state)
            ARB_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ARB_BUSY;
                end else begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            ARB_BUSY: begin
                if (w_requesting[r_grant_idx]) begin
                    mem_wen   = req_wen[r_grant_idx];
                    mem_ren   = req_ren[r_grant_idx] & ~req_wen[r_grant_idx];
                    mem_addr  = req_addr[r_grant_idx];
                    mem_store = req_store[r_grant_idx];
                    if (!mem_wait) begin
                        w_done                = 1'b1;
                        req_wait[r_grant_idx] = 1'b0;
                        req_load[r_grant_idx] = mem_load;
                        w_state_nxt           = ARB_IDLE;
                    end else begin
                        w_state_nxt = ARB_BUSY;
                    end
                end else begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench: a 2-channel fixed-priority arbiter and a 4-channel
// round-robin arbiter driven with hand-computed expectations.
module tb_cache_mem_arbiter;
    import caches_pkg::*;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    logic [1:0]        f_ren, f_wen, f_req_wait;
    logic [1:0][31:0]  f_addr;
    logic [1:0][63:0]  f_store, f_req_load;
    logic              f_mem_ren, f_mem_wen, f_wait, f_gv;
    logic [31:0]       f_mem_addr;
    logic [63:0]       f_mem_store, f_mload;
    logic [0:0]        f_gidx;

    logic [3:0]        q_ren, q_wen, q_req_wait;
    logic [3:0][31:0]  q_addr;
    logic [3:0][63:0]  q_store, q_req_load;
    logic              q_mem_ren, q_mem_wen, q_wait, q_gv;
    logic [31:0]       q_mem_addr;
    logic [63:0]       q_mem_store, q_mload;
    logic [1:0]        q_gidx;

    int n_checks = 0;
    int n_errors = 0;
    int exp_g;

    cache_mem_arbiter #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(64), .ARB_MODE(ARB_FIXED)) u_fix (
        .CLK(CLK), .RST(RST), .req_ren(f_ren), .req_wen(f_wen), .req_addr(f_addr),
        .req_store(f_store), .req_wait(f_req_wait), .req_load(f_req_load),
        .mem_ren(f_mem_ren), .mem_wen(f_mem_wen), .mem_addr(f_mem_addr),
        .mem_store(f_mem_store), .mem_wait(f_wait), .mem_load(f_mload),
        .grant_valid(f_gv), .grant_idx(f_gidx)
    );

    cache_mem_arbiter #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(64), .ARB_MODE(ARB_RR)) u_rr (
        .CLK(CLK), .RST(RST), .req_ren(q_ren), .req_wen(q_wen), .req_addr(q_addr),
        .req_store(q_store), .req_wait(q_req_wait), .req_load(q_req_load),
        .mem_ren(q_mem_ren), .mem_wen(q_mem_wen), .mem_addr(q_mem_addr),
        .mem_store(q_mem_store), .mem_wait(q_wait), .mem_load(q_mload),
        .grant_valid(q_gv), .grant_idx(q_gidx)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    initial begin
        RST = 1'b1;
        f_ren = 2'b00; f_wen = 2'b00; f_addr = '0; f_store = '0; f_wait = 1'b1; f_mload = '0;
        q_ren = 4'b0000; q_wen = 4'b0000; q_store = '0; q_wait = 1'b1; q_mload = '0;
        for (int i = 0; i < 4; i++) begin
            q_addr[i]  = 32'h0000_1000 + 32'(i * 16);
            q_store[i] = 64'h5000_0000_0000_0000 + 64'(i);
        end
        #3;
        chk("rst_f_gv", f_gv, 64'd0);
        chk("rst_f_mem_ren", f_mem_ren, 64'd0);
        chk("rst_f_mem_addr", f_mem_addr, 64'd0);
        chk("rst_q_gidx", q_gidx, 64'd0);
        chk("rst_q_req_wait", q_req_wait, 64'd0);
        chk("rst_q_req_load0", q_req_load[0], 64'd0);
        nxt();
        RST = 1'b0;

        // Fixed priority: simultaneous ch0 read and ch1 write
        nxt();
        f_ren = 2'b01; f_wen = 2'b10;
        f_addr[0] = 32'h0000_0100; f_addr[1] = 32'h0000_0200;
        f_store[1] = 64'hDEAD_BEEF_0000_1111;
        smp();
        chk("t1_idle_gv", f_gv, 64'd0);
        chk("t1_idle_wait", f_req_wait, 64'h3);
        nxt(); smp();
        chk("t1_g0_gv", f_gv, 64'd1);
        chk("t1_g0_idx", f_gidx, 64'd0);
        chk("t1_g0_ren", f_mem_ren, 64'd1);
        chk("t1_g0_wen", f_mem_wen, 64'd0);
        chk("t1_g0_addr", f_mem_addr, 64'h100);
        chk("t1_g0_wait", f_req_wait, 64'h3);
        nxt();
        f_wait = 1'b0; f_mload = 64'h1234;
        smp();
        chk("t1_c0_wait", f_req_wait, 64'h2);
        chk("t1_c0_load0", f_req_load[0], 64'h1234);
        chk("t1_c0_load1", f_req_load[1], 64'd0);
        nxt();
        f_ren = 2'b00; f_wait = 1'b1;
        smp();
        chk("t1_bubble_gv", f_gv, 64'd0);
        chk("t1_bubble_addr", f_mem_addr, 64'd0);
        chk("t1_bubble_wen", f_mem_wen, 64'd0);
        chk("t1_bubble_wait", f_req_wait, 64'h2);
        nxt(); smp();
        chk("t1_g1_idx", f_gidx, 64'd1);
        chk("t1_g1_wen", f_mem_wen, 64'd1);
        chk("t1_g1_ren", f_mem_ren, 64'd0);
        chk("t1_g1_addr", f_mem_addr, 64'h200);
        chk("t1_g1_store", f_mem_store, 64'hDEAD_BEEF_0000_1111);
        nxt();
        f_wait = 1'b0; f_mload = 64'h55;
        smp();
        chk("t1_c1_wait", f_req_wait, 64'd0);
        chk("t1_c1_load1", f_req_load[1], 64'h55);
        chk("t1_c1_load0", f_req_load[0], 64'd0);
        nxt();
        f_wen = 2'b00; f_mload = 64'hAA;
        smp();
        chk("t6_idle_wait", f_req_wait, 64'd0);
        chk("t6_idle_load0", f_req_load[0], 64'd0);
        chk("t6_idle_load1", f_req_load[1], 64'd0);
        chk("t6_idle_gv", f_gv, 64'd0);

        // Round robin: all four reading, single-cycle accesses
        nxt();
        q_ren = 4'hF; q_wait = 1'b0;
        for (int k = 0; k < 5; k++) begin
            exp_g = k % 4;
            smp();
            chk("t2_idle_wait", q_req_wait, 64'hF);
            chk("t2_idle_gv", q_gv, 64'd0);
            nxt();
            q_mload = 64'hC0DE_0000 + 64'(k);
            smp();
            chk("t2_gidx", q_gidx, 64'(exp_g));
            chk("t2_addr", q_mem_addr, 64'h1000 + 64'(exp_g * 16));
            chk("t2_wait", q_req_wait, 64'(4'hF & ~(4'b0001 << exp_g)));
            chk("t2_load_own", q_req_load[exp_g], 64'hC0DE_0000 + 64'(k));
            chk("t2_load_other", q_req_load[(exp_g + 1) % 4], 64'd0);
            nxt();
        end

        // Write wins over read on the same channel (pointer now 1)
        q_ren = 4'b0100; q_wen = 4'b0100; q_wait = 1'b1;
        smp();
        chk("t3_idle_gv", q_gv, 64'd0);
        nxt(); smp();
        chk("t3_gidx", q_gidx, 64'd2);
        chk("t3_wen", q_mem_wen, 64'd1);
        chk("t3_ren", q_mem_ren, 64'd0);
        chk("t3_store", q_mem_store, 64'h5000_0000_0000_0002);
        nxt();
        q_wait = 1'b0;
        smp();
        chk("t3_done_wait", q_req_wait, 64'd0);

        // Abort: ch1 withdraws while memory is still waiting (pointer now 3)
        nxt();
        q_ren = 4'b0010; q_wen = 4'b0000; q_wait = 1'b1;
        smp();
        nxt(); smp();
        chk("t4_gidx", q_gidx, 64'd1);
        chk("t4_ren", q_mem_ren, 64'd1);
        nxt();
        q_ren = 4'b0000;
        smp();
        chk("t4_drop_ren", q_mem_ren, 64'd0);
        chk("t4_drop_addr", q_mem_addr, 64'd0);
        chk("t4_drop_wait", q_req_wait, 64'd0);
        chk("t4_drop_gv", q_gv, 64'd1);
        nxt(); smp();
        chk("t4_idle_gv", q_gv, 64'd0);
        q_ren = 4'b0101;
        nxt();
        q_wait = 1'b0;
        smp();
        chk("t4_ptr_kept", q_gidx, 64'd0);
        chk("t4_done_wait", q_req_wait, 64'h4);

        // Asynchronous reset in the middle of a BUSY transaction (pointer now 1)
        nxt();
        q_ren = 4'b0100; q_wait = 1'b1;
        smp();
        nxt(); smp();
        chk("t5_pre_gidx", q_gidx, 64'd2);
        chk("t5_pre_ren", q_mem_ren, 64'd1);
        #1 RST = 1'b1;
        #1;
        chk("t5_rst_ren", q_mem_ren, 64'd0);
        chk("t5_rst_addr", q_mem_addr, 64'd0);
        chk("t5_rst_gv", q_gv, 64'd0);
        chk("t5_rst_gidx", q_gidx, 64'd0);
        nxt();
        RST = 1'b0; q_ren = 4'b1001;
        smp();
        chk("t5_post_gv", q_gv, 64'd0);
        nxt(); smp();
        chk("t5_ptr_reset", q_gidx, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
